// File: rtl/regfile_2r1w_init.sv
// 2-read/1-write register file with registered read ports, write-through
// bypass, optional hardwired-zero register 0 and a reset-triggered INIT
// sequencer that clears the array one entry per cycle before asserting Ready.
module regfile_2r1w_init #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NREGS    = 32,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Rd_En,
    input  logic [ADDR_W-1:0] Add_A,
    input  logic [ADDR_W-1:0] Add_B,
    input  logic              Write_En,
    input  logic [ADDR_W-1:0] Add_Dest,
    input  logic [DATA_W-1:0] Write_Data,
    output logic [DATA_W-1:0] Info_A,
    output logic [DATA_W-1:0] Info_B,
    output logic              Info_Valid,
    output logic              Ready
);

    localparam int unsigned IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] NREGS_C = CNT_W'(NREGS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(NREGS - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [NREGS];
    state_t            state;
    logic [CNT_W-1:0]  init_cnt;

    logic              wr_ok_c;
    logic [DATA_W-1:0] rd_a_c;
    logic [DATA_W-1:0] rd_b_c;

    // Address maps to a real, writable/readable entry (not out of range, not hardwired zero)
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_C) && !(ZERO_REG && (a == '0));
    endfunction

    // Write qualification and read-port muxing with same-edge write-through
    always_comb begin
        wr_ok_c = (state == S_RUN) && Write_En && addr_live(Add_Dest);
        rd_a_c  = '0;
        rd_b_c  = '0;
        if (addr_live(Add_A)) begin
            rd_a_c = (wr_ok_c && (Add_A == Add_Dest)) ? Write_Data : mem[IDX_W'(Add_A)];
        end
        if (addr_live(Add_B)) begin
            rd_b_c = (wr_ok_c && (Add_B == Add_Dest)) ? Write_Data : mem[IDX_W'(Add_B)];
        end
    end

    // Storage: cleared entry by entry during INIT, written normally in RUN; never reset
    always_ff @(posedge CLK) begin
        if (state == S_INIT) begin
            mem[IDX_W'(init_cnt)] <= '0;
        end else if (wr_ok_c) begin
            mem[IDX_W'(Add_Dest)] <= Write_Data;
        end
    end

    // INIT/RUN sequencer and registered read outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            Info_A     <= '0;
            Info_B     <= '0;
            Info_Valid <= 1'b0;
            Ready      <= 1'b0;
        end else if (state == S_INIT) begin
            Info_Valid <= 1'b0;
            if (init_cnt == LAST_C) begin
                state <= S_RUN;
                Ready <= 1'b1;
            end else begin
                init_cnt <= init_cnt + CNT_W'(1);
            end
        end else begin
            Info_Valid <= Rd_En;
            if (Rd_En) begin
                Info_A <= rd_a_c;
                Info_B <= rd_b_c;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_init.sv
// Self-checking bench: two register files (32 regs with zero reg, 16 regs
// without) share one stimulus stream and are compared every cycle against
// an array-based behavioural model, plus directed literal checks.
module tb_regfile_2r1w_init;

    logic        CLK;
    logic        RST;
    logic        Rd_En;
    logic [4:0]  Add_A;
    logic [4:0]  Add_B;
    logic        Write_En;
    logic [4:0]  Add_Dest;
    logic [31:0] Write_Data;

    logic [31:0] a0, b0, a1, b1;
    logic        v0, r0, v1, r1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    regfile_2r1w_init #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .ZERO_REG(1'b1)) dut0 (
        .CLK(CLK), .RST(RST), .Rd_En(Rd_En), .Add_A(Add_A), .Add_B(Add_B),
        .Write_En(Write_En), .Add_Dest(Add_Dest), .Write_Data(Write_Data),
        .Info_A(a0), .Info_B(b0), .Info_Valid(v0), .Ready(r0)
    );

    regfile_2r1w_init #(.DATA_W(32), .ADDR_W(5), .NREGS(16), .ZERO_REG(1'b0)) dut1 (
        .CLK(CLK), .RST(RST), .Rd_En(Rd_En), .Add_A(Add_A), .Add_B(Add_B),
        .Write_En(Write_En), .Add_Dest(Add_Dest), .Write_Data(Write_Data),
        .Info_A(a1), .Info_B(b1), .Info_Valid(v1), .Ready(r1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic [31:0] m  [2][32];
    int          cnt[2];
    logic [31:0] ea [2];
    logic [31:0] eb [2];
    logic        ev [2];
    logic        er [2];

    function automatic int nr(input int i);
        return (i == 0) ? 32 : 16;
    endfunction

    function automatic bit live(input int i, input logic [4:0] a);
        return (int'(a) < nr(i)) && !(i == 0 && a == 5'd0);
    endfunction

    function automatic logic [31:0] mrd(input int i, input logic [4:0] a);
        if (!live(i, a)) return 32'd0;
        if (Write_En && live(i, Add_Dest) && a == Add_Dest) return Write_Data;
        return m[i][a];
    endfunction

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                cnt[i] = 0; ea[i] = 32'd0; eb[i] = 32'd0; ev[i] = 1'b0; er[i] = 1'b0;
            end else if (cnt[i] < nr(i)) begin
                cnt[i] = cnt[i] + 1;
                ev[i] = 1'b0;
                if (cnt[i] == nr(i)) begin
                    er[i] = 1'b1;
                    for (int k = 0; k < 32; k++) m[i][k] = 32'd0;
                end
            end else begin
                if (Rd_En) begin
                    ea[i] = mrd(i, Add_A);
                    eb[i] = mrd(i, Add_B);
                end
                ev[i] = Rd_En;
                if (Write_En && live(i, Add_Dest)) m[i][Add_Dest] = Write_Data;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_on) begin
            chk("cyc_a0", a0, ea[0]);
            chk("cyc_b0", b0, eb[0]);
            chk("cyc_v0", 32'(v0), 32'(ev[0]));
            chk("cyc_r0", 32'(r0), 32'(er[0]));
            chk("cyc_a1", a1, ea[1]);
            chk("cyc_b1", b1, eb[1]);
            chk("cyc_v1", 32'(v1), 32'(ev[1]));
            chk("cyc_r1", 32'(r1), 32'(er[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic rd, input logic [4:0] a, input logic [4:0] b,
                         input logic we, input logic [4:0] d, input logic [31:0] wd);
        Rd_En = rd; Add_A = a; Add_B = b; Write_En = we; Add_Dest = d; Write_Data = wd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic count_ready(output int k0, output int k1);
        k0 = 0; k1 = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k0 == 0 && r0) k0 = k;
            if (k1 == 0 && r1) k1 = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k1;
        RST = 1'b1;
        idle();
        #1 chk_on = 1'b1;
        chk("rst_ready0", 32'(r0), 32'd0);
        chk("rst_info_a0", a0, 32'd0);
        tick();
        RST = 1'b0;

        // T1: INIT length and all-zero contents
        count_ready(k0, k1);
        chk("t1_init_edges_32", 32'(k0), 32'd32);
        chk("t1_init_edges_16", 32'(k1), 32'd16);
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'(a), 5'(31 - a), 1'b0, 5'd0, 32'd0);
            tick();
            chk("t1_zero_a0", a0, 32'd0);
            chk("t1_zero_b1", b1, 32'd0);
        end

        // T2: write then read
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t2_rd_a0", a0, 32'hDEADBEEF);
        chk("t2_valid0", 32'(v0), 32'd1);
        chk("t2_rd_a1", a1, 32'hDEADBEEF);
        chk("t2_model", ea[0], 32'hDEADBEEF);

        // T3: write-through bypass on both ports
        drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1234);
        tick();
        chk("t3_bypass_a0", a0, 32'h1234);
        chk("t3_bypass_b0", b0, 32'h1234);
        chk("t3_bypass_b1", b1, 32'h1234);

        // T4: zero register
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t4_zero_reg", a0, 32'd0);
        chk("t4_plain_reg0", a1, 32'hFFFFFFFF);
        chk("t4_model", ea[1], 32'hFFFFFFFF);

        // T5: out-of-range address on the 16-entry instance
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'hAA);
        tick();
        drive(1'b1, 5'd20, 5'd5, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t5_oor_a1", a1, 32'd0);
        chk("t5_keep_b1", b1, 32'hDEADBEEF);
        chk("t5_inrange_a0", a0, 32'hAA);

        // Rd_En low: valid drops, data holds
        idle();
        tick();
        chk("hold_valid0", 32'(v0), 32'd0);
        chk("hold_a0", a0, 32'hAA);

        // T6: reset mid-RUN after writing reg 3
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h55);
        tick();
        idle();
        RST = 1'b1;
        #1;
        chk("t6_run_ready_drop", 32'(r0), 32'd0);
        chk("t6_run_info_a0", a0, 32'd0);
        chk("t6_run_ready1_drop", 32'(r1), 32'd0);
        @(posedge CLK); #2;
        RST = 1'b0;
        count_ready(k0, k1);
        chk("t6_run_edges", 32'(k0), 32'd32);
        drive(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t6_reg3_a0", a0, 32'd0);
        chk("t6_reg3_a1", a1, 32'd0);

        // T6: reset mid-INIT at edge 10
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        #1;
        chk("t6_init_ready", 32'(r1), 32'd0);
        @(posedge CLK); #2;
        RST = 1'b0;
        count_ready(k0, k1);
        chk("t6_init_edges", 32'(k0), 32'd32);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                idle();
                RST = 1'b1;
                tick();
                RST = 1'b0;
            end
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
                  $urandom());
            tick();
        end

        idle();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
